// File: rtl/mc_core_hs.sv
// -----------------------------------------------------------------------------
// mc_core_hs -- multicycle MIPS-subset core (datapath + main FSM + ALU decode)
//
// The core executes lw, sw, R-type (add/sub/and/or/slt), beq and j. One unified
// word-addressed instruction/data memory sits outside the block, behind a
// req/ready handshake. The PC advances by 1 per instruction.
//
// Optional feature macro: MC_EXT_OPS_EN
//   defined   : addi (08h) and bne (05h) are executed
//   undefined : the addi/bne states are not built; 08h/05h raise illegal_op
//
// Parameters
//   M        datapath/register width (32 or 64); instruction = mem_rdata[31:0]
//   N        register address width (5 -> 32 registers, $0 reads as 0)
//   RESET_PC PC value loaded on reset
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   RST           synchronous active-high reset
//   mem_req       memory request valid
//   mem_we        1 = write, 0 = read (valid with mem_req)
//   mem_addr      word address (valid with mem_req)
//   mem_wdata     store data (valid with mem_req & mem_we)
//   mem_ready     transfer completes on an edge with mem_req & mem_ready
//   mem_rdata     read data, sampled on the completing edge
//   instr_retired 1-cycle pulse in the final state of each instruction
//   illegal_op    1-cycle pulse on an unsupported opcode or funct
//   pc_dbg        current PC
//   state_dbg     current FSM state encoding
// -----------------------------------------------------------------------------
module mc_core_hs #(
    parameter int             M        = 32,
    parameter int             N        = 5,
    parameter logic [M-1:0]   RESET_PC = '0
) (
    input  logic         CLK,
    input  logic         RST,
    output logic         mem_req,
    output logic         mem_we,
    output logic [M-1:0] mem_addr,
    output logic [M-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [M-1:0] mem_rdata,
    output logic         instr_retired,
    output logic         illegal_op,
    output logic [M-1:0] pc_dbg,
    output logic [3:0]   state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_BNE    = 4'd12
    } state_t;

    // architectural and inter-state registers
    state_t         r_state;
    state_t         w_state_next;
    logic [M-1:0]   r_pc;
    logic [31:0]    r_ir;
    logic [M-1:0]   r_a;
    logic [M-1:0]   r_b;
    logic [M-1:0]   r_aluout;
    logic [M-1:0]   r_mdr;

    // instruction fields
    logic [5:0]     w_op;
    logic [5:0]     w_funct;
    logic [N-1:0]   w_rs;
    logic [N-1:0]   w_rt;
    logic [N-1:0]   w_rd;
    logic [M-1:0]   w_simm;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{(M-16){r_ir[15]}}, r_ir[15:0]};

    // FSM-driven control
    logic           w_req;
    logic           w_we;
    logic [M-1:0]   w_addr;
    logic           w_retire;
    logic           w_illegal;
    logic           w_rf_we;
    logic [N-1:0]   w_rf_waddr;
    logic [M-1:0]   w_rf_wdata;

    // ALU
    logic [M-1:0]   w_alu;
    logic           w_funct_ok;

    // -------------------------------------------------------------------------
    // Register file: entry 0 is a constant zero, so writes to $0 vanish and
    // reads of $0 always see 0.
    // -------------------------------------------------------------------------
    logic [M-1:0] w_rf [2**N];

    genvar gi;
    generate
        for (gi = 0; gi < 2**N; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign w_rf[gi] = '0;
            end else begin : g_reg
                logic [M-1:0] r_q;
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        r_q <= '0;
                    end else if (w_rf_we && (w_rf_waddr == N'(gi))) begin
                        r_q <= w_rf_wdata;
                    end
                end
                assign w_rf[gi] = r_q;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // ALU decode for R-type; w_funct_ok drops for unsupported funct codes
    // -------------------------------------------------------------------------
    always_comb begin
        w_alu      = '0;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'h20:   w_alu = r_a + r_b;
            6'h22:   w_alu = r_a - r_b;
            6'h24:   w_alu = r_a & r_b;
            6'h25:   w_alu = r_a | r_b;
            6'h2A:   w_alu = {{(M-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default: w_funct_ok = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_pc;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_waddr   = '0;
        w_rf_wdata   = r_aluout;

        case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = r_pc;
                if (mem_ready) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    6'h00:        w_state_next = S_EXEC;
                    6'h23, 6'h2B: w_state_next = S_MEMADR;
                    6'h04:        w_state_next = S_BEQ;
                    6'h02:        w_state_next = S_JUMP;
`ifdef MC_EXT_OPS_EN
                    6'h08:        w_state_next = S_ADDIEX;
                    6'h05:        w_state_next = S_BNE;
`endif
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_state_next = (w_op == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_req  = 1'b1;
                w_addr = r_aluout;
                if (mem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_rt;
                w_rf_wdata   = r_mdr;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                // stores retire on the completing cycle of the handshake
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_addr = r_aluout;
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                if (w_funct_ok) begin
                    w_state_next = S_ALUWB;
                end else begin
                    w_illegal    = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_ALUWB: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_rd;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BEQ, S_JUMP: begin
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
`ifdef MC_EXT_OPS_EN
            S_ADDIEX: begin
                w_state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_rt;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BNE: begin
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
`endif
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata[31:0];
                        r_pc <= r_pc + {{(M-1){1'b0}}, 1'b1};
                    end
                end
                S_DECODE: begin
                    // branch target is computed against the already-incremented PC
                    r_a      <= w_rf[w_rs];
                    r_b      <= w_rf[w_rt];
                    r_aluout <= r_pc + w_simm;
                end
                S_MEMADR: begin
                    r_aluout <= r_a + w_simm;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        r_mdr <= mem_rdata;
                    end
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                end
                S_BEQ: begin
                    if (r_a == r_b) begin
                        r_pc <= r_aluout;
                    end
                end
                S_JUMP: begin
                    r_pc <= {r_pc[M-1:26], r_ir[25:0]};
                end
`ifdef MC_EXT_OPS_EN
                S_ADDIEX: begin
                    r_aluout <= r_a + w_simm;
                end
                S_BNE: begin
                    if (r_a != r_b) begin
                        r_pc <= r_aluout;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: strobes are masked while RST is high so an interrupted
    // transfer is dropped in the reset cycle itself.
    // -------------------------------------------------------------------------
    assign mem_req       = w_req & ~RST;
    assign mem_we        = w_we & ~RST;
    assign mem_addr      = w_addr;
    assign mem_wdata     = r_b;
    assign instr_retired = w_retire & ~RST;
    assign illegal_op    = w_illegal & ~RST;
    assign pc_dbg        = r_pc;
    assign state_dbg     = r_state;

endmodule
